param_multifunc_reg: RTL
========================

// Module: param_multifunc_reg
// PURPOSE
//  Parametrised multi-function data register: load, shift, rotate, increment, decrement, hold.
//  - Operation selected per cycle by a 3-bit opcode; generalised in WIDTH and step size.
//  - Adds carry/zero status, a serial input and a clock enable.
//  - Datapath-side register block; a testbench or control FSM drives it directly.
// PARAMETERS
//  WIDTH  4  data width in bits (>=2)
//  STEP   1  shift/rotate distance and inc/dec amount (1..WIDTH-1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  en         in   1      clock enable; 0 = hold all state
//  control    in   3      opcode (see BEHAVIOUR)
//  data_in    in   WIDTH  parallel load value
//  serial_in  in   1      fill bit for shl/shr
//  data_out   out  WIDTH  register value
//  carry_out  out  1      shifted-out / wrap (or clamp) flag
//  zero       out  1      1 when data_out == 0
// BEHAVIOUR
//  - Interface is fixed: one clock, reset synchronous and active-high.
//  - Reset values: data_out=0, carry_out=0, zero=1.
//  - All outputs registered; 1-cycle latency from control/data sample to output.
//  - Priority at each edge: rst > en=0 (hold all, carry included) > opcode.
//  - Opcodes (q = data_out, S = STEP):
//    000 HOLD  q unchanged, carry unchanged
//    001 LOAD  q=data_in, carry=0
//    010 SHL   q={q[W-1-S:0],{S{serial_in}}}, carry=q[W-S]
//    011 SHR   q={{S{serial_in}},q[W-1:S]}, carry=q[S-1]
//    100 ROTL  q rotated left by S, carry=q[W-S]
//    101 ROTR  q rotated right by S, carry=q[S-1]
//    110 INC   q=(q+S) mod 2^W, carry=1 if wrapped, else 0
//    111 DEC   q=(q-S) mod 2^W, carry=1 if borrowed, else 0
//  - carry = last bit to leave q (bit adjacent to the remaining field).
//  - zero is registered with the new q value in the same edge; never lags by a cycle.
//  - Arithmetic is unsigned, computed in WIDTH+1 bits; MSB is the carry/borrow.
//  - rst asserted together with en=1 and any opcode: reset wins.
//  - en deasserted mid-sequence: state frozen; resumes from frozen value on re-assert.
//  - Out-of-range STEP is an elaboration error, flagged by a generate-time check.
// CONFIGURATION
//  Macro PARAM_MULTIFUNC_REG_SATURATE_EN:
//  - Defined: INC clamps at 2^W-1 and DEC clamps at 0; carry=1 when a clamp occurred.
//  - Undefined (default): INC/DEC wrap modulo 2^W as specified above.
//  - Shift/rotate/load/hold are unaffected by the macro.
// STRUCTURE
//  - Package param_multifunc_reg_pkg:
//    - opcode localparams OP_HOLD..OP_DEC (3-bit), and opcode_t typedef.
//  - Sub-module pmr_next_val: combinational next-value/next-carry from (q, control, data_in, serial_in).
//  - Top holds only the q/carry/zero flops, enable and reset logic.
// TESTING (WIDTH=4, STEP=1 unless noted)
//  1. rst=1 for 1 cycle, any opcode -> data_out=0, carry_out=0, zero=1.
//  2. LOAD 4'hA, then SHL with serial_in=1 -> data_out=4'h5, carry_out=1.
//  3. LOAD 4'h1, then ROTR -> 4'h8, carry=1; then ROTL -> 4'h1, carry=1.
//  4. LOAD 4'hF, INC -> 4'h0, carry=1, zero=1; with SATURATE_EN -> 4'hF, carry=1, zero=0.
//  5. LOAD 4'h0, DEC -> 4'hF, carry=1; with SATURATE_EN -> 4'h0, carry=1, zero=1.
//  6. en=0 with LOAD 4'h7 -> no change; rst=1 with en=1 LOAD -> 0; STEP=2: LOAD 4'b1011, SHR -> 4'b0010, carry=1.

Source files
------------

// File: rtl/param_multifunc_reg_pkg.sv
// Shared opcode encoding for the multi-function data register.
package param_multifunc_reg_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_HOLD = 3'b000;
  localparam opcode_t OP_LOAD = 3'b001;
  localparam opcode_t OP_SHL  = 3'b010;
  localparam opcode_t OP_SHR  = 3'b011;
  localparam opcode_t OP_ROTL = 3'b100;
  localparam opcode_t OP_ROTR = 3'b101;
  localparam opcode_t OP_INC  = 3'b110;
  localparam opcode_t OP_DEC  = 3'b111;

endpackage

// File: rtl/pmr_next_val.sv
// Combinational next value and next carry for param_multifunc_reg.
// Macro PARAM_MULTIFUNC_REG_SATURATE_EN makes INC/DEC clamp instead of wrap.
module pmr_next_val
  import param_multifunc_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             carry,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_q,
  output logic             next_carry
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // MSB of the widened result is the carry (INC) or borrow (DEC)
  assign sum  = {1'b0, q} + STEP_EXT;
  assign diff = {1'b0, q} - STEP_EXT;

  always_comb begin
    next_q     = q;
    next_carry = carry;
    case (opcode_t'(control))
      OP_HOLD: begin
        next_q     = q;
        next_carry = carry;
      end
      OP_LOAD: begin
        next_q     = data_in;
        next_carry = 1'b0;
      end
      OP_SHL: begin
        next_q     = {q[WIDTH-1-STEP:0], {STEP{serial_in}}};
        next_carry = q[WIDTH-STEP];
      end
      OP_SHR: begin
        next_q     = {{STEP{serial_in}}, q[WIDTH-1:STEP]};
        next_carry = q[STEP-1];
      end
      OP_ROTL: begin
        next_q     = {q[WIDTH-1-STEP:0], q[WIDTH-1:WIDTH-STEP]};
        next_carry = q[WIDTH-STEP];
      end
      OP_ROTR: begin
        next_q     = {q[STEP-1:0], q[WIDTH-1:STEP]};
        next_carry = q[STEP-1];
      end
      OP_INC: begin
        next_carry = sum[WIDTH];
`ifdef PARAM_MULTIFUNC_REG_SATURATE_EN
        next_q     = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        next_q     = sum[WIDTH-1:0];
`endif
      end
      OP_DEC: begin
        next_carry = diff[WIDTH];
`ifdef PARAM_MULTIFUNC_REG_SATURATE_EN
        next_q     = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        next_q     = diff[WIDTH-1:0];
`endif
      end
      default: begin
        next_q     = q;
        next_carry = carry;
      end
    endcase
  end

endmodule

// File: rtl/param_multifunc_reg.sv
// Multi-function data register: q/carry/zero flops with enable and sync reset.
// Optional macro PARAM_MULTIFUNC_REG_SATURATE_EN (see pmr_next_val) clamps INC/DEC.
module param_multifunc_reg
  import param_multifunc_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             zero
);

  if (WIDTH < 2 || STEP < 1 || STEP > WIDTH - 1) begin : g_bad_params
    $error("param_multifunc_reg: need WIDTH>=2 and 1<=STEP<=WIDTH-1 (WIDTH=%0d STEP=%0d)",
           WIDTH, STEP);
  end

  logic [WIDTH-1:0] next_q;
  logic             next_carry;

  pmr_next_val #(.WIDTH(WIDTH), .STEP(STEP)) u_next_val (
    .q          (data_out),
    .carry      (carry_out),
    .control    (control),
    .data_in    (data_in),
    .serial_in  (serial_in),
    .next_q     (next_q),
    .next_carry (next_carry)
  );

  // zero is derived from next_q so it updates on the same edge as data_out
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
    end else if (en) begin
      data_out  <= next_q;
      carry_out <= next_carry;
      zero      <= (next_q == '0);
    end
  end

endmodule
